// File: rtl/taxi_axil_xbar_pkg.sv
// Shared types for the AXI4-lite crossbar response stages.
// Holds the response-code enum and the head-of-queue state encoding used by the R/B return stages.
package taxi_axil_xbar_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    HEAD_EMPTY,
    HEAD_FWD,
    HEAD_ERR
  } head_state_e;

  // Select field width for a crossbar with n master interfaces (never narrower than 1 bit).
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/taxi_axil_crossbar_cmd_fifo.sv
// Generic synchronous FIFO with registered pointers, full/empty and occupancy count.
// Shared by the crossbar read (R) and write (B) response return stages.
module taxi_axil_crossbar_cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/taxi_axil_crossbar_rresp.sv
// Per-slave read response return stage: queues reply commands in order, then steers R beats or generates DECERR.
// Build option TAXI_AXIL_XBAR_RRESP_REG_EN adds a full-throughput registered output stage.
module taxi_axil_crossbar_rresp
  import taxi_axil_xbar_pkg::*;
#(
  parameter int M_COUNT   = 4,
  parameter int SEL_W     = sel_width(M_COUNT),
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEL_W-1:0]            s_rc_select,
  input  logic                        s_rc_decerr,
  input  logic                        s_rc_valid,
  output logic                        s_rc_ready,
  input  logic [M_COUNT*DATA_W-1:0]   m_axil_rdata,
  input  logic [M_COUNT*2-1:0]        m_axil_rresp,
  input  logic [M_COUNT-1:0]          m_axil_rvalid,
  output logic [M_COUNT-1:0]          m_axil_rready,
  output logic [DATA_W-1:0]           s_axil_rdata,
  output logic [1:0]                  s_axil_rresp,
  output logic                        s_axil_rvalid,
  input  logic                        s_axil_rready,
  output logic [$clog2(CMD_DEPTH):0]  outstanding
);

  // Command entry; its width depends on SEL_W so it lives here rather than in the package.
  typedef struct packed {
    logic             decerr;
    logic [SEL_W-1:0] select;
  } cmd_t;

  cmd_t              push_cmd, head_cmd;
  logic              fifo_full, fifo_empty, pop;
  logic              sel_ok;
  head_state_e       head_st;
  logic [M_COUNT-1:0] lane_sel;
  logic              lane_valid;
  logic [DATA_W-1:0] lane_data;
  logic [1:0]        lane_resp;
  logic              beat_valid;
  logic [DATA_W-1:0] beat_data;
  resp_t             beat_resp;

  assign push_cmd   = '{decerr: s_rc_decerr, select: s_rc_select};
  assign s_rc_ready = !fifo_full && !rst;

  taxi_axil_crossbar_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_rc_valid),
    .data_i  (push_cmd),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .data_o  (head_cmd),
    .empty_o (fifo_empty),
    .count_o (outstanding)
  );

  assign sel_ok = int'(head_cmd.select) < M_COUNT;

  // Out-of-range selects are answered locally, exactly like a failed decode.
  always_comb begin
    head_st = HEAD_EMPTY;
    if (!rst && !fifo_empty) head_st = (head_cmd.decerr || !sel_ok) ? HEAD_ERR : HEAD_FWD;
  end

  always_comb begin
    lane_sel   = '0;
    lane_valid = 1'b0;
    lane_data  = '0;
    lane_resp  = OKAY;
    for (int k = 0; k < M_COUNT; k++) begin
      if (head_st == HEAD_FWD && head_cmd.select == SEL_W'(k)) begin
        lane_sel[k] = 1'b1;
        lane_valid  = m_axil_rvalid[k];
        lane_data   = m_axil_rdata[k*DATA_W +: DATA_W];
        lane_resp   = m_axil_rresp[k*2 +: 2];
      end
    end
  end

  assign beat_valid = (head_st == HEAD_ERR) || lane_valid;
  assign beat_data  = (head_st == HEAD_ERR) ? '0 : lane_data;
  assign beat_resp  = (head_st == HEAD_ERR) ? DECERR : resp_t'(lane_resp);

`ifdef TAXI_AXIL_XBAR_RRESP_REG_EN
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_resp_q, out_resp_d;
  logic              take;

  // The register accepts a new beat whenever it is empty or draining this cycle.
  assign take          = !out_valid_q || s_axil_rready;
  assign m_axil_rready = lane_sel & {M_COUNT{take}};
  assign pop           = beat_valid && take;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_resp_d  = out_resp_q;
    if (s_axil_rready) out_valid_d = 1'b0;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_data;
      out_resp_d  = beat_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_resp_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_resp_q  <= out_resp_d;
    end
  end

  assign s_axil_rvalid = out_valid_q;
  assign s_axil_rdata  = out_data_q;
  assign s_axil_rresp  = out_resp_q;
`else
  assign m_axil_rready = lane_sel & {M_COUNT{s_axil_rready}};
  assign pop           = beat_valid && s_axil_rready;
  assign s_axil_rvalid = beat_valid;
  assign s_axil_rdata  = beat_data;
  assign s_axil_rresp  = beat_resp;
`endif

`ifndef SYNTHESIS
  illegal_select: assert property (@(posedge clk) disable iff (rst)
    !(head_st != HEAD_EMPTY && !head_cmd.decerr && !sel_ok));
`endif

endmodule
